// File: rtl/bilinear_pkg.sv
// bilinear_pkg: register map, bit indices, FSM encoding and launch validation shared by the controller
package bilinear_pkg;
  localparam logic [3:0] REG_CTRL    = 4'd0;
  localparam logic [3:0] REG_STATUS  = 4'd1;
  localparam logic [3:0] REG_IN_DIM  = 4'd2;
  localparam logic [3:0] REG_SCALE   = 4'd3;
  localparam logic [3:0] REG_OUT_DIM = 4'd4;
  localparam logic [3:0] REG_CYCLES  = 4'd5;
  localparam logic [3:0] REG_FLOPS   = 4'd6;
  localparam logic [3:0] REG_RDS     = 4'd7;
  localparam logic [3:0] REG_WRS     = 4'd8;

  localparam int CTRL_START   = 0;
  localparam int CTRL_STEP_EN = 1;
  localparam int CTRL_STEP    = 2;
  localparam int CTRL_IRQ_EN  = 3;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;

  localparam logic [15:0] MIN_DIM = 16'd2;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_CAPTURE} state_e;

  typedef struct packed {
    logic        step_en;
    logic        irq_en;
    logic [15:0] in_w;
    logic [15:0] in_h;
    logic [15:0] scale;
    logic        done;
    logic        err;
    logic [15:0] out_w;
    logic [15:0] out_h;
    logic [31:0] flops;
    logic [31:0] rds;
    logic [31:0] wrs;
  } regs_t;

  // A launch is refused when the output image would be degenerate or not fit the core's output memory
  function automatic logic cfg_err(input logic [15:0] w, input logic [15:0] h,
                                   input logic [15:0] scale, input int aw);
    logic [31:0] ow, oh, area;
    ow   = ({16'd0, w} * {16'd0, scale}) >> 8;
    oh   = ({16'd0, h} * {16'd0, scale}) >> 8;
    area = ow * oh;
    return (w < MIN_DIM) || (h < MIN_DIM) || (scale == 16'd0) || (ow == 32'd0) ||
           (oh == 32'd0) || (area > (32'd1 << aw));
  endfunction
endpackage

// File: rtl/bilinear_ctrl_regs.sv
// bilinear_ctrl_regs: register file, sticky status flags and registered read port
module bilinear_ctrl_regs
  import bilinear_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  reg_addr,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  input  state_e      state,
  input  logic        core_busy,
  input  logic        capture,
  input  logic        err_set,
  input  logic [15:0] core_out_w,
  input  logic [15:0] core_out_h,
  input  logic [31:0] core_flop_count,
  input  logic [31:0] core_mem_rd_count,
  input  logic [31:0] core_mem_wr_count,
  input  logic [31:0] cycles,
  output logic        start_req,
  output logic        step_req,
  output logic        step_en,
  output logic        irq,
  output logic [15:0] in_w,
  output logic [15:0] in_h,
  output logic [15:0] scale
);
  regs_t       r_q, r_d;
  logic [31:0] rdata_q, rdata_d, rmux;
  logic        wr_ctrl, wr_status, idle;

  assign wr_ctrl   = reg_wr && (reg_addr == REG_CTRL);
  assign wr_status = reg_wr && (reg_addr == REG_STATUS);
  assign idle      = state == S_IDLE;
  assign start_req = wr_ctrl && reg_wdata[CTRL_START];
  assign step_req  = wr_ctrl && reg_wdata[CTRL_STEP];
  assign step_en   = r_q.step_en;
  assign irq       = (r_q.done | r_q.err) & r_q.irq_en;
  assign in_w      = r_q.in_w;
  assign in_h      = r_q.in_h;
  assign scale     = r_q.scale;
  assign reg_rdata = rdata_q;

  // Register writes; configuration is frozen outside IDLE and a flag set beats its W1C clear
  always_comb begin
    r_d = r_q;
    if (wr_ctrl) begin
      r_d.step_en = reg_wdata[CTRL_STEP_EN];
      r_d.irq_en  = reg_wdata[CTRL_IRQ_EN];
    end
    if (reg_wr && idle && (reg_addr == REG_IN_DIM)) {r_d.in_h, r_d.in_w} = reg_wdata;
    if (reg_wr && idle && (reg_addr == REG_SCALE)) r_d.scale = reg_wdata[15:0];
    r_d.done = (r_q.done & ~(wr_status & reg_wdata[ST_DONE])) | capture;
    r_d.err  = (r_q.err & ~(wr_status & reg_wdata[ST_ERR])) | err_set;
    if (capture) begin
      r_d.out_w = core_out_w;
      r_d.out_h = core_out_h;
      r_d.flops = core_flop_count;
      r_d.rds   = core_mem_rd_count;
      r_d.wrs   = core_mem_wr_count;
    end
  end

  // Read mux; read data is captured only on a read strobe and held otherwise
  always_comb begin
    case (reg_addr)
      REG_CTRL:    rmux = {28'd0, r_q.irq_en, 1'b0, r_q.step_en, 1'b0};
      REG_STATUS:  rmux = {26'd0, state, 1'b0, r_q.err, r_q.done, (!idle) | core_busy};
      REG_IN_DIM:  rmux = {r_q.in_h, r_q.in_w};
      REG_SCALE:   rmux = {16'd0, r_q.scale};
      REG_OUT_DIM: rmux = {r_q.out_h, r_q.out_w};
      REG_CYCLES:  rmux = cycles;
      REG_FLOPS:   rmux = r_q.flops;
      REG_RDS:     rmux = r_q.rds;
      REG_WRS:     rmux = r_q.wrs;
      default:     rmux = 32'd0;
    endcase
    rdata_d = reg_rd ? rmux : rdata_q;
  end

  // Register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q     <= '0;
      rdata_q <= '0;
    end else begin
      r_q     <= r_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: rtl/bilinear_ctrl.sv
// bilinear_ctrl: launch/run/capture sequencer and cycle counter for the bilinear scaler core
module bilinear_ctrl
  import bilinear_pkg::*;
#(
  parameter int AW = 19
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  reg_addr,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        irq,
  output logic        core_start,
  output logic        core_step_en,
  output logic        core_step_pulse,
  output logic [15:0] core_in_w,
  output logic [15:0] core_in_h,
  output logic [15:0] core_scale_q88,
  input  logic        core_busy,
  input  logic        core_done,
  input  logic [15:0] core_out_w,
  input  logic [15:0] core_out_h,
  input  logic [31:0] core_flop_count,
  input  logic [31:0] core_mem_rd_count,
  input  logic [31:0] core_mem_wr_count
);
  state_e      state_q, state_d;
  logic [31:0] cycles_q, cycles_d;
  logic        step_pulse_q, step_pulse_d;
  logic        start_req, step_req, err_set;

  assign core_start      = state_q == S_LAUNCH;
  assign core_step_pulse = step_pulse_q;

  bilinear_ctrl_regs u_regs (
    .clk               (clk),
    .rst_n             (rst_n),
    .reg_addr          (reg_addr),
    .reg_wr            (reg_wr),
    .reg_rd            (reg_rd),
    .reg_wdata         (reg_wdata),
    .reg_rdata         (reg_rdata),
    .state             (state_q),
    .core_busy         (core_busy),
    .capture           (state_q == S_CAPTURE),
    .err_set           (err_set),
    .core_out_w        (core_out_w),
    .core_out_h        (core_out_h),
    .core_flop_count   (core_flop_count),
    .core_mem_rd_count (core_mem_rd_count),
    .core_mem_wr_count (core_mem_wr_count),
    .cycles            (cycles_q),
    .start_req         (start_req),
    .step_req          (step_req),
    .step_en           (core_step_en),
    .irq               (irq),
    .in_w              (core_in_w),
    .in_h              (core_in_h),
    .scale             (core_scale_q88)
  );

  // Sequencer next state, saturating run-cycle count and step gating
  always_comb begin
    state_d      = state_q;
    cycles_d     = cycles_q;
    err_set      = 1'b0;
    step_pulse_d = step_req && (state_q == S_RUN) && core_step_en;
    case (state_q)
      S_IDLE: if (start_req) begin
        err_set = cfg_err(core_in_w, core_in_h, core_scale_q88, AW);
        state_d = err_set ? S_IDLE : S_LAUNCH;
      end
      S_LAUNCH: begin
        cycles_d = 32'd0;
        state_d  = S_RUN;
      end
      S_RUN: begin
        cycles_d = (&cycles_q) ? cycles_q : cycles_q + 32'd1;
        state_d  = core_done ? S_CAPTURE : S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cycles_q     <= '0;
      step_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cycles_q     <= cycles_d;
      step_pulse_q <= step_pulse_d;
    end
  end
endmodule

// File: tb/tb_bilinear_ctrl.sv
// tb_bilinear_ctrl: randomized and directed checks of bilinear_ctrl against a behavioural model and core stand-in
module tb_bilinear_ctrl;
  localparam int AW = 8;
  logic clk = 0, rst_n = 0;
  logic [3:0] reg_addr = 0;
  logic reg_wr = 0, reg_rd = 0;
  logic [31:0] reg_wdata = 0, reg_rdata;
  logic irq, core_start, core_step_en, core_step_pulse;
  logic [15:0] core_in_w, core_in_h, core_scale_q88;
  logic core_busy, core_done;
  logic [15:0] core_out_w, core_out_h;
  logic [31:0] core_flop_count, core_mem_rd_count, core_mem_wr_count;

  always #5 clk = ~clk;

  bilinear_ctrl #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .reg_addr(reg_addr), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .irq(irq), .core_start(core_start),
    .core_step_en(core_step_en), .core_step_pulse(core_step_pulse), .core_in_w(core_in_w),
    .core_in_h(core_in_h), .core_scale_q88(core_scale_q88), .core_busy(core_busy),
    .core_done(core_done), .core_out_w(core_out_w), .core_out_h(core_out_h),
    .core_flop_count(core_flop_count), .core_mem_rd_count(core_mem_rd_count),
    .core_mem_wr_count(core_mem_wr_count)
  );

  int checks = 0, failures = 0, n_start = 0, n_pulse = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 launch, 2 run, 3 capture
  logic [1:0]  m_ph = 0;
  logic        m_step_en = 0, m_irq_en = 0, m_done = 0, m_err = 0, m_pulse = 0;
  logic [15:0] m_w = 0, m_h = 0, m_s = 0, m_ow = 0, m_oh = 0;
  logic [31:0] m_cyc = 0, m_fl = 0, m_rd = 0, m_wr = 0, m_rdata = 0;
  logic        x_ctrl, x_stat, x_start, x_step, x_bad;

  function automatic bit cfg_bad(input int w, input int h, input int s);
    longint ow = (longint'(w) * s) / 256;
    longint oh = (longint'(h) * s) / 256;
    return w < 2 || h < 2 || s == 0 || ow == 0 || oh == 0 || ow * oh > (longint'(1) << AW);
  endfunction

  function automatic logic [31:0] mrd(input logic [3:0] a);
    case (a)
      4'd0: return {28'd0, m_irq_en, 1'b0, m_step_en, 1'b0};
      4'd1: return {26'd0, m_ph, 1'b0, m_err, m_done, (m_ph != 2'd0) | core_busy};
      4'd2: return {m_h, m_w};
      4'd3: return {16'd0, m_s};
      4'd4: return {m_oh, m_ow};
      4'd5: return m_cyc;
      4'd6: return m_fl;
      4'd7: return m_rd;
      4'd8: return m_wr;
      default: return 32'd0;
    endcase
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_ph = 0; m_step_en = 0; m_irq_en = 0; m_done = 0; m_err = 0; m_pulse = 0;
      m_w = 0; m_h = 0; m_s = 0; m_ow = 0; m_oh = 0;
      m_cyc = 0; m_fl = 0; m_rd = 0; m_wr = 0; m_rdata = 0;
    end else begin
      if (reg_rd) m_rdata = mrd(reg_addr);
      x_ctrl  = reg_wr && reg_addr == 4'd0;
      x_stat  = reg_wr && reg_addr == 4'd1;
      x_start = x_ctrl && reg_wdata[0];
      x_step  = x_ctrl && reg_wdata[2];
      x_bad   = cfg_bad(int'(m_w), int'(m_h), int'(m_s));
      m_pulse = x_step && m_ph == 2 && m_step_en;
      m_done  = (m_done && !(x_stat && reg_wdata[1])) || m_ph == 3;
      m_err   = (m_err && !(x_stat && reg_wdata[2])) || (m_ph == 0 && x_start && x_bad);
      if (x_ctrl) begin m_step_en = reg_wdata[1]; m_irq_en = reg_wdata[3]; end
      if (reg_wr && m_ph == 0 && reg_addr == 4'd2) {m_h, m_w} = reg_wdata;
      if (reg_wr && m_ph == 0 && reg_addr == 4'd3) m_s = reg_wdata[15:0];
      if (m_ph == 3) begin
        m_ow = core_out_w; m_oh = core_out_h;
        m_fl = core_flop_count; m_rd = core_mem_rd_count; m_wr = core_mem_wr_count;
      end
      if (m_ph == 1) m_cyc = 0;
      if (m_ph == 2 && m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
      case (m_ph)
        2'd0: m_ph = (x_start && !x_bad) ? 2'd1 : 2'd0;
        2'd1: m_ph = 2'd2;
        2'd2: m_ph = core_done ? 2'd3 : 2'd2;
        default: m_ph = 2'd0;
      endcase
    end
  end

  // Core stand-in: one pixel per cycle, or one per step pulse when stepping; 4 reads and 11 flops per pixel
  int c_tot = 0;
  bit c_act = 0;
  initial begin
    core_busy = 0; core_done = 0; core_out_w = 0; core_out_h = 0;
    core_flop_count = 0; core_mem_rd_count = 0; core_mem_wr_count = 0;
    forever begin
      @(posedge clk); #1;
      core_done = 0;
      if (!rst_n) begin
        c_act = 0; core_busy = 0; core_out_w = 0; core_out_h = 0;
        core_flop_count = 0; core_mem_rd_count = 0; core_mem_wr_count = 0;
      end else if (core_start) begin
        core_out_w = 16'((int'(core_in_w) * int'(core_scale_q88)) / 256);
        core_out_h = 16'((int'(core_in_h) * int'(core_scale_q88)) / 256);
        c_tot = int'(core_out_w) * int'(core_out_h);
        core_flop_count = 0; core_mem_rd_count = 0; core_mem_wr_count = 0;
        c_act = 1; core_busy = 1;
      end else if (c_act && (!core_step_en || core_step_pulse)) begin
        core_mem_wr_count = core_mem_wr_count + 1;
        core_mem_rd_count = core_mem_rd_count + 4;
        core_flop_count = core_flop_count + 11;
        if (int'(core_mem_wr_count) == c_tot) begin core_done = 1; c_act = 0; core_busy = 0; end
      end
    end
  end

  // Every cycle the DUT outputs must match the model
  initial forever begin
    @(negedge clk);
    if (core_start) n_start++;
    if (core_step_pulse) n_pulse++;
    chk("core_start", 32'(core_start), 32'(m_ph == 2'd1));
    chk("core_step_pulse", 32'(core_step_pulse), 32'(m_pulse));
    chk("core_step_en", 32'(core_step_en), 32'(m_step_en));
    chk("core_in_w", 32'(core_in_w), 32'(m_w));
    chk("core_in_h", 32'(core_in_h), 32'(m_h));
    chk("core_scale", 32'(core_scale_q88), 32'(m_s));
    chk("irq", 32'(irq), 32'((m_done | m_err) & m_irq_en));
    chk("reg_rdata", reg_rdata, m_rdata);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    reg_addr = a; reg_wdata = d; reg_wr = 1; tick(); reg_wr = 0;
  endtask
  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    reg_addr = a; reg_rd = 1; tick(); reg_rd = 0; d = reg_rdata;
  endtask
  task automatic rdchk(input string nm, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d); chk(nm, d, exp);
  endtask
  task automatic do_reset();
    rst_n = 0; tick(3); rst_n = 1; tick();
  endtask
  task automatic wait_ph(input logic [1:0] ph, input int lim);
    int n = 0;
    while (m_ph != ph && n < lim) begin tick(); n++; end
    if (m_ph != ph) begin chk("wait_timeout", 32'(m_ph), 32'(ph)); do_reset(); end
  endtask

  int s0;
  logic [31:0] d, ctrl;
  initial begin
    tick(3); rst_n = 1; tick();
    rdchk("reset_status", 1, 0);
    rdchk("reset_cycles", 5, 0);
    chk("reset_irq", 32'(irq), 0);
    // 4x4 at 2.0 -> 8x8
    wr(0, 8); wr(2, 32'h0004_0004); wr(3, 32'h200); s0 = n_start; wr(0, 9); wait_ph(0, 500);
    chk("one_start", n_start - s0, 1);
    rdchk("out_dim", 4, 32'h0008_0008);
    rdchk("wrs", 8, 64); rdchk("rds", 7, 256); rdchk("flops", 6, 704); rdchk("cycles", 5, 64);
    rdchk("status_done", 1, 2);
    chk("irq_done", 32'(irq), 1);
    wr(1, 2); chk("irq_cleared", 32'(irq), 0);
    // bad configurations
    wr(2, 32'h0004_0001); s0 = n_start; wr(0, 9); tick(3);
    rdchk("status_err_h1", 1, 4); chk("no_start_h1", n_start - s0, 0); chk("irq_err", 32'(irq), 1);
    wr(1, 4); wr(2, 32'h0004_0004); wr(3, 0); s0 = n_start; wr(0, 9); tick(3);
    rdchk("status_err_s0", 1, 4); chk("no_start_s0", n_start - s0, 0); wr(1, 4);
    wr(2, 32'h0010_0011); wr(3, 32'h100); wr(0, 9); tick(2); rdchk("status_err_area", 1, 4); wr(1, 4);
    wr(2, 32'h0010_0010); wr(0, 9); wait_ph(0, 600);
    rdchk("area_limit_ok", 4, 32'h0010_0010); wr(1, 2);
    wr(2, 32'h0002_0002); wr(3, 32'h7F); wr(0, 9); tick(2); rdchk("status_err_out0", 1, 4); wr(1, 4);
    wr(3, 32'h80); wr(0, 9); wait_ph(0, 50); rdchk("out_1x1", 4, 32'h0001_0001); wr(1, 2);
    // single stepping
    wr(0, 2); wr(2, 32'h0002_0002); wr(3, 32'h100); s0 = n_pulse; wr(0, 6); tick(3);
    chk("idle_step_ignored", n_pulse - s0, 0);
    wr(0, 3); tick(5); rdchk("status_run", 1, 32'h21);
    for (int i = 0; i < 3; i++) begin wr(0, 6); tick(4); end
    rdchk("still_run", 1, 32'h21);
    wr(0, 6); wait_ph(0, 50);
    chk("four_pulses", n_pulse - s0, 4);
    rdchk("step_wrs", 8, 4); rdchk("step_done", 1, 2); wr(1, 2); wr(0, 8);
    // config and START ignored while running
    wr(2, 32'h0008_0008); wr(3, 32'h200); s0 = n_start; wr(0, 9); tick(5);
    wr(2, 32'h0010_0010); wr(3, 32'h300); wr(0, 9);
    rdchk("dim_frozen", 2, 32'h0008_0008); rdchk("scale_frozen", 3, 32'h200);
    wait_ph(0, 600); chk("no_restart", n_start - s0, 1); rdchk("run_out_dim", 4, 32'h0010_0010); wr(1, 2);
    // W1C colliding with capture
    wr(2, 32'h0002_0002); wr(3, 32'h100); wr(0, 9); wait_ph(3, 100); wr(1, 2);
    rdchk("set_beats_clear", 1, 2); chk("irq_after_collide", 32'(irq), 1);
    wr(1, 2); chk("irq_after_clear", 32'(irq), 0); rdchk("status_clear", 1, 0);
    // reset mid-run
    wr(2, 32'h0008_0008); wr(3, 32'h200); wr(0, 9); tick(20);
    rst_n = 0; tick();
    chk("rst_start", 32'(core_start), 0); chk("rst_irq", 32'(irq), 0); chk("rst_rdata", reg_rdata, 0);
    chk("rst_in_w", 32'(core_in_w), 0); chk("rst_pulse", 32'(core_step_pulse), 0);
    tick(2); rst_n = 1; tick();
    rdchk("rst_status", 1, 0); rdchk("rst_cycles", 5, 0); rdchk("rst_dim", 2, 0);
    wr(2, 32'h0002_0002); wr(3, 32'h100); wr(0, 1); wait_ph(0, 50);
    rdchk("post_rst_out", 4, 32'h0002_0002); rdchk("post_rst_wrs", 8, 4); rdchk("post_rst_done", 1, 2); wr(1, 2);
    // randomized runs against the model
    for (int it = 0; it < 50; it++) begin
      ctrl = {28'd0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 3) == 0), 1'b0};
      wr(0, ctrl);
      wr(2, {16'($urandom_range(1, 10)), 16'($urandom_range(1, 10))});
      wr(3, ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(32'h40, 32'h300)));
      wr(0, ctrl | 1);
      for (int n = 0; n < 3000 && m_ph != 0; n++) begin
        case ($urandom_range(0, 7))
          0, 1, 2: if (ctrl[1]) wr(0, ctrl | 4); else tick();
          3: rd(4'($urandom_range(0, 15)), d);
          4: wr(2, $urandom);
          5: wr(0, ctrl | 1);
          6: wr(1, $urandom & 6);
          default: tick();
        endcase
      end
      wait_ph(0, 1);
      for (int a = 0; a < 16; a++) rd(4'(a), d);
      wr(1, $urandom & 6);
    end
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    failures++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/bilinear_ctrl.md
BILINEAR_CTRL -- requirements
Module: bilinear_ctrl

Interface
REQ-001 SHALL have parameter AW, default 19, meaning the address width of the core's output image memory.
REQ-002 SHALL have port clk, input, 1 bit: clock; reset rst_n, asynchronous, active-low.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port reg_addr, input, 4 bits: word address of the register being accessed.
REQ-005 SHALL have ports reg_wr and reg_rd, inputs, 1 bit each: single-cycle write and read strobes.
REQ-006 SHALL have port reg_wdata, input, 32 bits, and port reg_rdata, output, 32 bits, valid the cycle after reg_rd.
REQ-007 SHALL have port irq, output, 1 bit: level interrupt, equal to (done_sticky | err_sticky) & irq_en.
REQ-008 SHALL have outputs core_start, core_step_en and core_step_pulse, 1 bit each, driving the core's control inputs.
REQ-009 SHALL have outputs core_in_w, core_in_h and core_scale_q88, 16 bits each.
REQ-010 SHALL have inputs core_busy and core_done, 1 bit each; core_done is a one-cycle pulse.
REQ-011 SHALL have inputs core_out_w and core_out_h, 16 bits each.
REQ-012 SHALL have inputs core_flop_count, core_mem_rd_count and core_mem_wr_count, 32 bits each.

Function
REQ-013 The register map SHALL be:
- 0 CTRL: bit0 START (W1 pulse), bit1 STEP_EN, bit2 STEP (W1 pulse), bit3 IRQ_EN.
- 1 STATUS: bit0 busy (RO), bit1 done_sticky (W1C), bit2 err_sticky (W1C), bits[5:4] FSM state (RO).
- 2 IN_DIM: {h[31:16], w[15:0]}.
- 3 SCALE: Q8.8 scale in [15:0].
- 4 OUT_DIM: {out_h, out_w} (RO).
- 5 CYCLES, 6 FLOPS, 7 RDS, 8 WRS (RO).
- Unmapped addresses read 0.
REQ-014 The FSM SHALL have states IDLE, LAUNCH, RUN and CAPTURE.
REQ-015 In IDLE, a START write SHALL validate the configuration:
- error if w<2, h<2, scale==0, or ((w*scale)>>8)==0 or ((h*scale)>>8)==0;
- error if out_w*out_h exceeds 2^AW, computed at 32-bit width;
- on error, set err_sticky, stay in IDLE, and never assert core_start;
- otherwise go to LAUNCH.
REQ-016 In LAUNCH, core_start SHALL be high for exactly one cycle, CYCLES SHALL clear to 0, and the FSM SHALL go to RUN.
REQ-017 In RUN, CYCLES SHALL increment once per cycle, saturating at 0xFFFFFFFF, until core_done is seen; then the FSM SHALL go to CAPTURE.
REQ-018 In CAPTURE, the block SHALL latch OUT_DIM, FLOPS, RDS and WRS from the core, set done_sticky, and return to IDLE (1 cycle).
REQ-019 A STEP write SHALL produce one core_step_pulse cycle, and only when state==RUN and STEP_EN==1; in any other case it SHALL be ignored.
REQ-020 core_step_en SHALL equal the CTRL.STEP_EN register at all times.
REQ-021 Writes to IN_DIM and SCALE while state!=IDLE SHALL be ignored, and START while state!=IDLE SHALL be ignored.
REQ-022 STATUS.busy SHALL equal (state!=IDLE) | core_busy.
REQ-023 A sticky-flag set and a W1C clear of the same flag in the same cycle SHALL resolve with set winning.
REQ-024 reg_rdata SHALL be registered, with read data one cycle after reg_rd, and SHALL hold its value otherwise.

Reset
REQ-025 While rst_n is low, all registers SHALL clear: state=IDLE, outputs 0, core_in_w/core_in_h/core_scale_q88=0, counters 0, sticky flags 0, irq=0, reg_rdata=0.
REQ-026 Reset asserted mid-RUN SHALL return the block to IDLE with no CAPTURE; the core shares rst_n.

Structure
REQ-027 Package bilinear_pkg SHALL hold the register offsets, the CTRL/STATUS bit indices, the FSM state enum (2 bits) and ERR validation constants (minimum dimension 2).
REQ-028 Sub-module bilinear_ctrl_regs (register file, read mux, W1C/sticky logic) SHALL be separated from the FSM and counters in bilinear_ctrl.

Verification
REQ-029 IN_DIM=0x0004_0004, SCALE=0x0200, START -> one core_start pulse; after core_done, OUT_DIM=0x0008_0008, WRS=64, RDS=256, FLOPS=704, done_sticky=1, irq=1 (IRQ_EN=1).
REQ-030 IN_DIM=0x0004_0001, START -> err_sticky=1, core_start never asserted, state stays IDLE; SCALE=0 gives the same result.
REQ-031 STEP_EN=1, IN_DIM=0x0002_0002, SCALE=0x0100 -> the core stalls after each pixel; four STEP writes -> core_done, WRS=4; a STEP written in IDLE produces no pulse.
REQ-032 Writes to IN_DIM=0x0010_0010 and START during RUN -> register readback unchanged, no second core_start.
REQ-033 W1C of done_sticky written in the same cycle as CAPTURE -> done_sticky=1; a W1C one cycle later -> 0 and irq deasserts.
REQ-034 rst_n pulsed low mid-RUN -> all outputs 0, STATUS=0; a subsequent valid START runs normally.
